// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES-128 definitions for the iterative decryptor:
//   - state_t      : FSM state encoding of aes_decrypt_iter
//   - SBOX         : forward S-box, used only by the key schedule
//   - INV_SBOX     : inverse S-box, used by the inverse round
//   - rcon()       : round constant Rcon[i], i = 1..10
//   - xtime/gmul   : GF(2^8) arithmetic modulo x^8+x^4+x^3+x+1
//   - next_round_key() : one step of the AES-128 key expansion
// Byte order follows FIPS-197: byte 0 of a 128-bit block is bits 127:120.
// -----------------------------------------------------------------------------
package aes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        KEYEXP,
        INIT,
        ROUND,
        FINAL
    } state_t;

    // Element 0 is the most significant byte of each table.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add multiply; with a constant b this folds to a few XORs.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    // Round key i from round key i-1: w0 mixes RotWord/SubWord/Rcon of the
    // previous last word, the remaining words chain through XOR.
    function automatic logic [127:0] next_round_key(input logic [127:0] prev,
                                                    input logic [3:0]   i);
        logic [31:0] w0, w1, w2, w3;
        w0 = prev[127:96] ^ sub_word({prev[23:0], prev[31:24]}) ^ {rcon(i), 24'h000000};
        w1 = prev[95:64] ^ w0;
        w2 = prev[63:32] ^ w1;
        w3 = prev[31:0]  ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// -----------------------------------------------------------------------------
// aes_inv_round
// Combinational AES inverse round:
//   InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (skipped when
//   last_round is high).
// Ports:
//   state_in   [127:0] in   current state (FIPS-197 byte order)
//   round_key  [127:0] in   round key to add
//   last_round         in   1 = final round, no InvMixColumns
//   state_out  [127:0] out  next state
// -----------------------------------------------------------------------------
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         last_round,
    output logic [127:0] state_out
);

    logic [127:0] sub_bytes;
    logic [127:0] added;
    logic [127:0] mixed;

    // Byte (row r, column c) sits at index 4*c + r. InvShiftRows rotates row r
    // right by r, so output column c takes row r from input column c - r.
    always_comb begin
        // NOTE: every variable driven in always_comb gets a default first so no
        // path leaves it unassigned, which is what would infer a latch.
        sub_bytes = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sub_bytes[127 - 8*(4*c + r) -: 8] =
                    INV_SBOX[state_in[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8]];
            end
        end
    end

    assign added = sub_bytes ^ round_key;

    always_comb begin
        mixed = '0;
        for (int c = 0; c < 4; c++) begin
            logic [7:0] a0, a1, a2, a3;
            a0 = added[127 - 32*c -: 8];
            a1 = added[119 - 32*c -: 8];
            a2 = added[111 - 32*c -: 8];
            a3 = added[103 - 32*c -: 8];
            mixed[127 - 32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            mixed[119 - 32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            mixed[111 - 32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            mixed[103 - 32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
    end

    assign state_out = last_round ? added : mixed;

endmodule

// File: rtl/aes_decrypt_iter.sv
// -----------------------------------------------------------------------------
// aes_decrypt_iter
// Iterative AES-128 decryptor, one round per clock. Key expansion runs on
// demand (10 cycles) and is skipped when KEY_REUSE != 0 and the requested key
// matches the key whose schedule is already stored.
// Ports:
//   clk              in   clock, rising edge
//   rst              in   synchronous active-high reset, aborts any operation
//   start            in   request pulse, honoured only in IDLE
//   key      [127:0] in   cipher key, sampled with start
//   data_in  [127:0] in   ciphertext, sampled with start
//   busy             out  high whenever the FSM is not in IDLE
//   data_out [127:0] out  plaintext, held until the next done
//   done             out  one-cycle pulse, data_out valid in the same cycle
// Latency: done is high 22 cycles after the start-sampling edge's cycle with
// key expansion, 12 on a key-cache hit.
// -----------------------------------------------------------------------------
module aes_decrypt_iter
    import aes_pkg::*;
#(
    parameter int KEY_REUSE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] data_in,
    output logic         busy,
    output logic [127:0] data_out,
    output logic         done
);

    state_t       state;
    logic [3:0]   cnt;          // key index in KEYEXP, round index in ROUND/FINAL
    logic [127:0] blk;          // working state
    logic [127:0] round_keys [0:10];
    logic [127:0] cache_key;
    logic         cache_valid;
    logic         cache_hit;
    logic [127:0] rk_next;
    logic [127:0] round_out;

    assign cache_hit = (KEY_REUSE != 0) && cache_valid && (key == cache_key);
    assign rk_next   = next_round_key(round_keys[cnt - 4'd1], cnt);

    // cnt reaches 0 in FINAL, so the same lookup supplies rk0 there.
    aes_inv_round u_inv_round (
        .state_in   (blk),
        .round_key  (round_keys[cnt]),
        .last_round (state == FINAL),
        .state_out  (round_out)
    );

    // NOTE: key storage carries no reset; its contents only matter after a
    // full expansion, and cache_valid (which is reset) guards every reuse.
    always_ff @(posedge clk) begin
        if (state == IDLE && start && !cache_hit) round_keys[0] <= key;
        if (state == KEYEXP)                      round_keys[cnt] <= rk_next;
        if (state == KEYEXP && cnt == 4'd10)      cache_key <= round_keys[0];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge regardless of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            data_out    <= '0;
            cache_valid <= 1'b0;
            cnt         <= '0;
            blk         <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        blk  <= data_in;
                        busy <= 1'b1;
                        if (cache_hit) begin
                            state <= INIT;
                        end else begin
                            state <= KEYEXP;
                            cnt   <= 4'd1;
                        end
                    end
                end
                KEYEXP: begin
                    if (cnt == 4'd10) begin
                        state       <= INIT;
                        cache_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                INIT: begin
                    blk   <= blk ^ round_keys[10];
                    cnt   <= 4'd9;
                    state <= ROUND;
                end
                ROUND: begin
                    blk <= round_out;
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= FINAL;
                end
                FINAL: begin
                    data_out <= round_out;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// -----------------------------------------------------------------------------
// tb_aes_decrypt_iter
// Scoreboarded bench for aes_decrypt_iter. dut_a uses the default key cache,
// dut_b has KEY_REUSE=0. Expected plaintext and latency are queued when a
// start is issued and compared when done appears.
// -----------------------------------------------------------------------------
module tb_aes_decrypt_iter;

    localparam logic [127:0] V1_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] V1_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] V1_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] V1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] V2_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] V2_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] V2_PT   = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_a, start_b;
    logic [127:0] key, data_in;
    logic         busy_a, busy_b, done_a, done_b;
    logic [127:0] data_out_a, data_out_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [127:0] pt;
        int           lat;
        int           t0;
        string        name;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;

    bit           model_cache_valid;
    logic [127:0] model_cache_key;

    aes_decrypt_iter dut_a (
        .clk(clk), .rst(rst), .start(start_a), .key(key), .data_in(data_in),
        .busy(busy_a), .data_out(data_out_a), .done(done_a)
    );

    aes_decrypt_iter #(.KEY_REUSE(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .key(key), .data_in(data_in),
        .busy(busy_b), .data_out(data_out_b), .done(done_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst === 1'b0 && done_a === 1'b1) begin
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL a_unexpected_done: done=1 at cycle %0d, required no done", cyc);
            end else begin
                e_a = q_a.pop_front();
                if (data_out_a !== e_a.pt) begin
                    errors++;
                    $display("FAIL a_%s_data: got %h, required %h", e_a.name, data_out_a, e_a.pt);
                end
                checks++;
                if (cyc - e_a.t0 != e_a.lat) begin
                    errors++;
                    $display("FAIL a_%s_latency: got %0d, required %0d", e_a.name, cyc - e_a.t0, e_a.lat);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0 && done_b === 1'b1) begin
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected_done: done=1 at cycle %0d, required no done", cyc);
            end else begin
                e_b = q_b.pop_front();
                if (data_out_b !== e_b.pt) begin
                    errors++;
                    $display("FAIL b_%s_data: got %h, required %h", e_b.name, data_out_b, e_b.pt);
                end
                checks++;
                if (cyc - e_b.t0 != e_b.lat) begin
                    errors++;
                    $display("FAIL b_%s_latency: got %0d, required %0d", e_b.name, cyc - e_b.t0, e_b.lat);
                end
            end
        end
    end

    // Called just after a negedge with dut_a idle; returns one negedge later.
    task automatic issue_a(input logic [127:0] k, input logic [127:0] ct,
                           input logic [127:0] pt, input string name);
        exp_t e;
        e.pt   = pt;
        e.lat  = (model_cache_valid && model_cache_key == k) ? 12 : 22;
        e.t0   = cyc;
        e.name = name;
        q_a.push_back(e);
        model_cache_valid = 1'b1;
        model_cache_key   = k;
        key     = k;
        data_in = ct;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL a_%s_busy: got %b, required 1", name, busy_a);
        end
    endtask

    task automatic issue_b(input logic [127:0] k, input logic [127:0] ct,
                           input logic [127:0] pt, input string name);
        exp_t e;
        e.pt   = pt;
        e.lat  = 22;
        e.t0   = cyc;
        e.name = name;
        q_b.push_back(e);
        key     = k;
        data_in = ct;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
    endtask

    task automatic wait_idle_a(input string name);
        int n = 0;
        while ((q_a.size() != 0 || busy_a !== 1'b0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            checks++;
            errors++;
            $display("FAIL a_%s_timeout: pending=%0d busy=%b, required drained", name, q_a.size(), busy_a);
            q_a.delete();
        end
    endtask

    task automatic wait_idle_b(input string name);
        int n = 0;
        while ((q_b.size() != 0 || busy_b !== 1'b0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            checks++;
            errors++;
            $display("FAIL b_%s_timeout: pending=%0d busy=%b, required drained", name, q_b.size(), busy_b);
            q_b.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy_a); end
        checks++;
        if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", done_a); end
        checks++;
        if (data_out_a !== 128'h0) begin errors++; $display("FAIL reset_data_out: got %h, required 0", data_out_a); end
        checks++;
        if (busy_b !== 1'b0) begin errors++; $display("FAIL reset_busy_b: got %b, required 0", busy_b); end
        rst = 1'b0;
        model_cache_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_vectors();
        issue_a(V1_KEY, V1_CT, V1_PT, "v1_cold");
        wait_idle_a("v1_cold");
        checks++;
        if (dut_a.round_keys[10] !== V1_RK10) begin
            errors++;
            $display("FAIL v1_rk10: got %h, required %h", dut_a.round_keys[10], V1_RK10);
        end
        issue_a(V2_KEY, V2_CT, V2_PT, "v2_cold");
        wait_idle_a("v2_cold");
    endtask

    task automatic test_key_reuse();
        issue_a(V2_KEY, V2_CT, V2_PT, "v2_hit");
        wait_idle_a("v2_hit");
        issue_a(V1_KEY, V1_CT, V1_PT, "v1_miss");
        wait_idle_a("v1_miss");
        issue_a(V1_KEY, V1_CT, V1_PT, "v1_hit");
        wait_idle_a("v1_hit");
    endtask

    task automatic test_no_reuse();
        issue_b(V1_KEY, V1_CT, V1_PT, "v1_first");
        wait_idle_b("v1_first");
        issue_b(V1_KEY, V1_CT, V1_PT, "v1_again");
        wait_idle_b("v1_again");
    endtask

    // A start with other key/data in cycle 5 must be dropped, and later
    // changes on key/data_in must not disturb the running block.
    task automatic start_while_busy(input logic [127:0] k, input logic [127:0] ct,
                                    input logic [127:0] pt, input logic [127:0] other_k,
                                    input logic [127:0] other_ct, input string name);
        issue_a(k, ct, pt, name);
        repeat (3) @(negedge clk);
        key     = other_k;
        data_in = other_ct;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        key     = ~k;
        data_in = ~ct;
        wait_idle_a(name);
        repeat (4) @(negedge clk);
        checks++;
        if (data_out_a !== pt) begin
            errors++;
            $display("FAIL %s_hold: got %h, required %h", name, data_out_a, pt);
        end
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: busy got %b, required 0", name, busy_a);
        end
    endtask

    task automatic test_start_while_busy();
        start_while_busy(V1_KEY, V1_CT, V1_PT, V2_KEY, V2_CT, "busy_round");
        start_while_busy(V2_KEY, V2_CT, V2_PT, V1_KEY, V1_CT, "busy_keyexp");
    endtask

    task automatic test_reset_mid_op();
        issue_a(V1_KEY, V1_CT, V1_PT, "prime_v1");
        wait_idle_a("prime_v1");
        issue_a(V1_KEY, V1_CT, V1_PT, "aborted");
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b, required 0", busy_a); end
        checks++;
        if (done_a !== 1'b0) begin errors++; $display("FAIL abort_done: got %b, required 0", done_a); end
        checks++;
        if (data_out_a !== 128'h0) begin errors++; $display("FAIL abort_data_out: got %h, required 0", data_out_a); end
        rst = 1'b0;
        q_a.delete();
        model_cache_valid = 1'b0;
        repeat (20) @(negedge clk);
        issue_a(V1_KEY, V1_CT, V1_PT, "after_abort");
        wait_idle_a("after_abort");
    endtask

    task automatic wait_done_a(input string name);
        int n = 0;
        while (done_a !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL %s_no_done: done got %b, required 1 within 40 cycles", name, done_a);
        end
    endtask

    task automatic test_back_to_back();
        issue_a(V1_KEY, V1_CT, V1_PT, "b2b_first");
        wait_done_a("b2b_first");
        issue_a(V2_KEY, V2_CT, V2_PT, "b2b_second");
        wait_done_a("b2b_second");
        issue_a(V2_KEY, V2_CT, V2_PT, "b2b_third");
        wait_idle_a("b2b_third");
    endtask

    initial begin
        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        key     = '0;
        data_in = '0;
        model_cache_valid = 1'b0;
        model_cache_key   = '0;
        @(negedge clk);
        test_reset();
        test_vectors();
        test_key_reuse();
        test_no_reuse();
        test_start_while_busy();
        test_reset_mid_op();
        test_back_to_back();
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/aes_decrypt_iter.md
AES_DECRYPT_ITER -- requirements
Module: aes_decrypt_iter

Interface
- REQ-001 SHALL have parameter KEY_REUSE, default 1: when 1, skip key expansion if key equals the cached expanded key.
- REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
- REQ-003 SHALL have port rst, input, 1, reset, synchronous and active-high.
- REQ-004 SHALL have port start, input, 1, request pulse; sampled only in IDLE.
- REQ-005 SHALL have port key, input, 128, AES-128 cipher key (FIPS-197 byte order, byte 0 = bits 127:120), sampled with start.
- REQ-006 SHALL have port data_in, input, 128, ciphertext block, sampled with start.
- REQ-007 SHALL have port busy, output, 1, high in every state except IDLE.
- REQ-008 SHALL have port data_out, output, 128, registered plaintext; held until the next done.
- REQ-009 SHALL have port done, output, 1, one-cycle pulse; data_out is valid in the same cycle.

Function
- REQ-010 SHALL implement the FIPS-197 inverse cipher for Nk=4, Nr=10, iteratively, one round per clock.
- REQ-011 SHALL use states IDLE, KEYEXP, INIT, ROUND, FINAL.
- REQ-012 In IDLE with start=1, SHALL latch key and data_in and go to KEYEXP; when KEY_REUSE=1, the cache is valid and key matches the cached key, SHALL go to INIT instead.
- REQ-013 KEYEXP SHALL last exactly 10 cycles, computing round key i (i=1..10) in cycle i using SubWord, RotWord and Rcon[i], and storing all 11 round keys.
- REQ-014 At KEYEXP exit, SHALL set the cache-valid flag and store the cached key.
- REQ-015 INIT SHALL last 1 cycle: state <= ciphertext XOR rk10.
- REQ-016 ROUND SHALL last 9 cycles (r=9..1): InvShiftRows, InvSubBytes, XOR rk_r, InvMixColumns.
- REQ-017 FINAL SHALL last 1 cycle: InvShiftRows, InvSubBytes, XOR rk0; result is registered into data_out, done pulses, and the state returns to IDLE.
- REQ-018 Latency from the start-sampling edge to done high SHALL be 22 cycles with key expansion and 12 cycles on a cache hit.
- REQ-019 start while busy=1 SHALL be ignored, with no queueing; changes on key and data_in while busy SHALL have no effect.
- REQ-020 start in the same cycle that done is high SHALL be accepted, because the state is already IDLE.
- REQ-021 All GF(2^8) arithmetic SHALL be mod x^8+x^4+x^3+x+1, with multiplies by 09, 0b, 0d and 0e.

Reset
- REQ-022 rst=1 SHALL force IDLE, busy=0, done=0 and data_out=0, and SHALL clear the cache-valid flag; stored round keys are don't-care.
- REQ-023 rst asserted mid-operation SHALL abort the operation: no done pulse, and data_out=0 on the next cycle.

Structure
- REQ-024 Shared package aes_pkg SHALL hold the Rcon table, the forward S-box (for the key schedule), the inverse S-box, the xtime/gmul functions, and the state-encoding constants.
- REQ-025 A single sub-module, aes_inv_round, SHALL implement the combinational round (InvShiftRows, InvSubBytes, AddRoundKey, optional InvMixColumns selected by a last-round input).
- REQ-026 The FSM, round counter and round-key storage SHALL reside in aes_decrypt_iter.

Verification
- REQ-027 Vector 1: key 2b7e151628aed2a6abf7158809cf4f3c, data_in 3925841d02dc09fbdc118597196a0b32 -> data_out 3243f6a8885a308d313198a2e0370734, done exactly 22 cycles after start; internal rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- REQ-028 Vector 2: key 000102030405060708090a0b0c0d0e0f, data_in 69c4e0d86a7b0430d8cdb78070b4c55a -> data_out 00112233445566778899aabbccddeeff.
- REQ-029 Key reuse: repeat Vector 2 with the same key -> same plaintext with done after 12 cycles; then Vector 1 -> 22 cycles; with KEY_REUSE=0, every operation takes 22 cycles.
- REQ-030 Start while busy: pulse start with a different key and data at cycle 5 of an operation -> ignored; Vector 1 result unchanged; done pulses exactly once.
- REQ-031 Reset mid-operation: assert rst in cycle 8 -> busy=0, done=0, data_out=0 next cycle; the following Vector 1 takes 22 cycles (cache cleared) and gives correct output.
- REQ-032 Back-to-back: assert start in the done cycle -> second operation accepted, and both data_out values are correct.
